// File: rtl/pipe_fetch_unit.sv
// pipe_fetch_unit: IF stage with a one-entry stall buffer and redirect drop.
// Optional FETCH_PERF_EN adds stall_cnt / redir_cnt performance counters.
module pipe_fetch_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  pcsource,
  input  logic        wpcir,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] dinst,
  output logic [31:0] dpc4,
  output logic        dvalid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] redir_cnt
`endif
);

  typedef enum logic [1:0] {
    S_REQ,
    S_HOLD,
    S_DROP
  } state_t;

  state_t      state;
  logic [31:0] buf_q;
  logic [31:0] tgt_q;
  logic [31:0] pc4;
  logic [31:0] target;
  logic        redir;
  logic        load;
  logic        bubble;

  // pcsource only means anything when ID actually accepts
  assign redir = wpcir & (pcsource != 2'b00);
  assign pc4   = pc + 32'd4;

  // A real instruction enters IF/ID from memory or from the stall buffer
  assign load = wpcir & ~redir &
                (((state == S_REQ) & imem_ready) |
                 (state == S_HOLD));

  // Any accepted cycle that does not carry an instruction is a bubble
  assign bubble = wpcir & ~load;

  // Pending request address is pc; in DROP pc still names the abandoned one
  assign imem_addr = pc;
  assign imem_req  = ~reset & (state != S_HOLD);

  // Select the redirect target
  always_comb begin
    target = 32'd0;
    unique case (1'b1)
      pcsource == 2'b01: target = bpc;
      pcsource == 2'b10: target = rpc;
      pcsource == 2'b11: target = jpc;
      default:           target = 32'd0;
    endcase
  end

  // Fetch FSM: pc, stall buffer, saved target and IF/ID register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= S_REQ;
      pc     <= 32'd0;
      buf_q  <= 32'd0;
      tgt_q  <= 32'd0;
      dinst  <= 32'd0;
      dpc4   <= 32'd0;
      dvalid <= 1'b0;
    end else begin
      if (load) begin
        dinst  <= (state == S_HOLD) ? buf_q : imem_rdata;
        dpc4   <= pc4;
        dvalid <= 1'b1;
      end else if (bubble) begin
        dinst  <= 32'd0;
        dpc4   <= 32'd0;
        dvalid <= 1'b0;
      end
      unique case (state)
        S_REQ: begin
          if (imem_ready) begin
            if (redir) begin
              pc <= target;
            end else if (wpcir) begin
              pc <= pc4;
            end else begin
              buf_q <= imem_rdata;
              state <= S_HOLD;
            end
          end else if (redir) begin
            tgt_q <= target;
            state <= S_DROP;
          end
        end
        S_HOLD: begin
          if (redir) begin
            pc    <= target;
            state <= S_REQ;
          end else if (wpcir) begin
            pc    <= pc4;
            state <= S_REQ;
          end
        end
        S_DROP: begin
          if (imem_ready) begin
            pc    <= redir ? target : tgt_q;
            state <= S_REQ;
          end else if (redir) begin
            tgt_q <= target;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  // Count bubbles loaded into IF/ID and accepted redirects
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt <= 32'd0;
      redir_cnt <= 32'd0;
    end else begin
      if (bubble) stall_cnt <= stall_cnt + 32'd1;
      if (redir)  redir_cnt <= redir_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/pipe_fetch_unit.md
PIPE_FETCH_UNIT -- requirements
Module: pipe_fetch_unit

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: pcsource  in  2  ID-stage next-PC select: 00 pc+4, 01 bpc, 10 rpc (jr), 11 jpc.
REQ-004 SHALL have ports: wpcir  in  1  ID accepts a new instruction this cycle (0 = load-use stall).
REQ-005 SHALL have ports: bpc / rpc / jpc  in  32 each  branch, register-jump and jump targets.
REQ-006 SHALL have ports: imem_req  out  1; imem_addr  out  32; imem_ready  in  1; imem_rdata  in  32.
REQ-007 SHALL have ports: pc  out  32  current fetch PC; dinst  out  32  and  dpc4  out  32  IF/ID register; dvalid  out  1  IF/ID holds a real instruction.

Function
REQ-008 SHALL define a redirect as wpcir=1 and pcsource!=00; pcsource SHALL be ignored while wpcir=0.
REQ-009 SHALL target bpc, rpc or jpc per pcsource on redirect; no delay slot, so the instruction after the redirecting one SHALL never reach IF/ID.
REQ-010 SHALL implement three states: REQ, HOLD, DROP.
REQ-011 SHALL assert imem_req=1 in REQ and DROP, and imem_req=0 in HOLD and during reset.
REQ-012 SHALL hold imem_addr constant from assertion until the imem_ready cycle; imem_addr = pc in REQ; in DROP, imem_addr = address of the abandoned request.
REQ-013 REQ, imem_ready=1, redirect: SHALL discard rdata, set pc to target, load bubble (dinst=0, dvalid=0), stay in REQ.
REQ-014 REQ, imem_ready=1, wpcir=1, no redirect: SHALL load dinst=rdata, dpc4=pc+4, dvalid=1, set pc to pc+4, stay in REQ; back-to-back fetch is 1 instruction/cycle at zero memory wait.
REQ-015 REQ, imem_ready=1, wpcir=0: SHALL hold the IF/ID register, capture rdata in a one-entry buffer, go to HOLD.
REQ-016 REQ, imem_ready=0, wpcir=1, no redirect: SHALL load bubble into IF/ID.
REQ-017 REQ, imem_ready=0, wpcir=0: SHALL hold IF/ID and pc.
REQ-018 REQ, imem_ready=0, redirect: SHALL save target, load bubble, go to DROP.
REQ-019 HOLD, wpcir=0: SHALL hold the buffer and IF/ID.
REQ-020 HOLD, wpcir=1, no redirect: SHALL load the buffer into IF/ID (dvalid=1), set pc to pc+4, go to REQ.
REQ-021 HOLD, redirect: SHALL discard the buffer, set pc to target, load bubble, go to REQ.
REQ-022 DROP SHALL load bubble whenever wpcir=1.
REQ-023 DROP, further redirect: SHALL overwrite the saved target (latest wins).
REQ-024 DROP, imem_ready=1: SHALL discard rdata, set pc to the saved target, go to REQ.
REQ-025 SHALL compute PC arithmetic modulo 2^32; pc=0xFFFFFFFC increments to 0x00000000.

Reset
REQ-026 On reset SHALL immediately force pc=0, dinst=0, dpc4=0, dvalid=0, buffer=0, saved target=0, state=REQ.
REQ-027 Reset mid-request SHALL abandon the outstanding imem access without waiting for imem_ready; first request after release SHALL be to address 0.

Configuration
REQ-028 With FETCH_PERF_EN defined, SHALL add outputs stall_cnt (32) and redir_cnt (32), reset to 0, wrapping at 2^32.
REQ-029 stall_cnt SHALL increment each cycle a bubble is loaded into IF/ID; redir_cnt SHALL increment per redirect.
REQ-030 Without FETCH_PERF_EN, the ports and counters SHALL be absent and all other behaviour identical.

Verification
REQ-031 Release reset, imem_ready=1 always, wpcir=1, pcsource=00 -> imem_addr 0,4,8,...; dpc4 4,8,12 with dvalid=1 on consecutive cycles.
REQ-032 pc=0x10, ready=1, pcsource=01, bpc=0x40 one cycle -> next dvalid=0, next imem_addr=0x40, 0x14 word never in IF/ID.
REQ-033 pc=0x20, ready=1, wpcir=0 for 2 cycles -> imem_req low 2 cycles, IF/ID unchanged; wpcir=1 -> dinst=word@0x20, dpc4=0x24, next addr 0x24.
REQ-034 Request 0x30 with ready=0, redirect jpc=0x100 -> imem_addr held 0x30 until ready, data dropped, next addr 0x100, dvalid=0 throughout.
REQ-035 Assert reset while ready=0 at addr 0x50 -> pc=0, dvalid=0 same cycle; after release, first addr 0.
REQ-036 FETCH_PERF_EN, 3 ready=0 cycles with wpcir=1 plus one redirect -> stall_cnt=4, redir_cnt=1 (bubble on redirect counted).
